// File: rtl/mem_addr_exc_sequencer_pkg.sv
// Shared types and constants for the memory-address / exception sequencer.
// The state enum, cause indices and normal-source encodings live here so the
// interface, the encoder and the top agree on a single definition.
package mem_addr_exc_sequencer_pkg;

  // Sequencer states: normal muxing, vector fetch, memory wait, handler capture
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VEC     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  // Exception cause indices (lower index wins when several are raised)
  localparam int EXC_NOOP = 0;
  localparam int EXC_OVF  = 1;
  localparam int EXC_DIV0 = 2;

  // Normal memory-address source encodings; the other src_sel codes give 0
  localparam logic [1:0] SRC_PC  = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;

  // Width of a cause index: at least one bit, even for a single cause
  function automatic int cause_width(input int num_exc);
    return (num_exc <= 1) ? 1 : $clog2(num_exc);
  endfunction

endpackage

// File: rtl/mem_addr_exc_sequencer_if.sv
// Bus between the control unit / datapath registers (master) and the
// memory-address exception sequencer (slave).
interface mem_addr_exc_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_EXC = 3
);
  import mem_addr_exc_sequencer_pkg::*;

  localparam int CAUSE_W = cause_width(NUM_EXC);

  logic [1:0]         src_sel;
  logic [WIDTH-1:0]   in_pc;
  logic [WIDTH-1:0]   in_alu_out;
  logic [NUM_EXC-1:0] exc_req;
  logic [7:0]         mem_rdata;
  logic [WIDTH-1:0]   mem_addr;
  logic               busy;
  logic [WIDTH-1:0]   epc;
  logic [CAUSE_W-1:0] exc_cause;
  logic [WIDTH-1:0]   handler_pc;
  logic               handler_valid;

  modport master (
    output src_sel, in_pc, in_alu_out, exc_req, mem_rdata,
    input  mem_addr, busy, epc, exc_cause, handler_pc, handler_valid
  );

  modport slave (
    input  src_sel, in_pc, in_alu_out, exc_req, mem_rdata,
    output mem_addr, busy, epc, exc_cause, handler_pc, handler_valid
  );

endinterface

// File: rtl/mem_addr_exc_sequencer_exc_priority_enc.sv
// Lowest-index-wins priority encoder over the exception request vector.
module exc_priority_enc #(
  parameter int NUM_EXC = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_EXC-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_addr_exc_sequencer.sv
// Memory-address source mux with a built-in exception entry sequence:
// save EPC, present the cause's vector address, wait out the memory read
// latency and capture the handler byte as the new PC.
// Optional macro MEM_ADDR_EXC_PENDING_EN: requests raised while busy are
// remembered and serviced after the current sequence instead of dropped.
module mem_addr_exc_sequencer
  import mem_addr_exc_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_EXC    = 3,
  parameter int VEC_BASE   = 253,
  parameter int MEM_LAT    = 1,
  parameter int EPC_OFFSET = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_addr_exc_sequencer_if.slave   bus
);

  localparam int               CAUSE_W    = cause_width(NUM_EXC);
  localparam int               CNT_W      = (MEM_LAT <= 1) ? 1 : $clog2(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [WIDTH-1:0] VEC_BASE_W = WIDTH'(VEC_BASE);
  localparam logic [WIDTH-1:0] EPC_OFF_W  = WIDTH'(EPC_OFFSET);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [WIDTH-1:0]   handler_pc_q, handler_pc_d;
  logic               handler_valid_q, handler_valid_d;
  logic [WIDTH-1:0]   mem_addr_c;
  logic [NUM_EXC-1:0] eff_req;
  logic [CAUSE_W-1:0] enc_idx;
  logic               enc_vld;

`ifdef MEM_ADDR_EXC_PENDING_EN
  logic [NUM_EXC-1:0] pending_q, pending_d;

  assign eff_req = bus.exc_req | pending_q;

  // Collect requests seen while busy; drop the one being serviced on entry
  always_comb begin
    pending_d = pending_q;
    if (state_q != IDLE) begin
      pending_d = pending_q | bus.exc_req;
    end else if (enc_vld) begin
      pending_d = pending_q & ~(NUM_EXC'(1) << enc_idx);
    end
  end

  // Pending request register
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end
`else
  assign eff_req = bus.exc_req;
`endif

  exc_priority_enc #(
    .NUM_EXC (NUM_EXC),
    .IDX_W   (CAUSE_W)
  ) u_enc (
    .req   (eff_req),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // State, wait counter and saved exception context registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      epc_q           <= '0;
      cause_q         <= '0;
      handler_pc_q    <= '0;
      handler_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      epc_q           <= epc_d;
      cause_q         <= cause_d;
      handler_pc_q    <= handler_pc_d;
      handler_valid_q <= handler_valid_d;
    end
  end

  // Next state: one vector cycle, MEM_LAT wait cycles, one capture cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enc_vld) begin
          state_d = VEC;
          cnt_d   = CNT_LOAD;
        end
      end
      VEC:  state_d = WAIT;
      WAIT: begin
        if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
        else             state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: address mux and updates to the saved context
  always_comb begin
    epc_d           = epc_q;
    cause_d         = cause_q;
    handler_pc_d    = handler_pc_q;
    handler_valid_d = 1'b0;
    mem_addr_c      = '0;
    if (state_q == IDLE) begin
      case (bus.src_sel)
        SRC_PC:  mem_addr_c = bus.in_pc;
        SRC_ALU: mem_addr_c = bus.in_alu_out;
        default: mem_addr_c = '0;
      endcase
      if (enc_vld) begin
        cause_d = enc_idx;
        epc_d   = bus.in_pc - EPC_OFF_W;
      end
    end else begin
      // Vector address is held through capture so the read stays stable
      mem_addr_c = VEC_BASE_W + WIDTH'(cause_q);
    end
    if (state_q == CAPTURE) begin
      handler_pc_d    = WIDTH'(bus.mem_rdata);
      handler_valid_d = 1'b1;
    end
  end

  assign bus.mem_addr      = mem_addr_c;
  assign bus.busy          = (state_q != IDLE);
  assign bus.epc           = epc_q;
  assign bus.exc_cause     = cause_q;
  assign bus.handler_pc    = handler_pc_q;
  assign bus.handler_valid = handler_valid_q;

endmodule

// File: tb/tb_mem_addr_exc_sequencer.sv
// Bench for mem_addr_exc_sequencer: two instances (MEM_LAT=1 and MEM_LAT=3)
// share stimulus; each is compared every cycle with a sequence-position model,
// and directed scenarios carry literal expectations.
module tb_mem_addr_exc_sequencer;

`ifdef MEM_ADDR_EXC_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_addr_exc_sequencer_if #(.WIDTH(32), .NUM_EXC(3)) if1 ();
  mem_addr_exc_sequencer_if #(.WIDTH(32), .NUM_EXC(3)) if3 ();

  mem_addr_exc_sequencer #(.WIDTH(32), .NUM_EXC(3), .VEC_BASE(253), .MEM_LAT(1), .EPC_OFFSET(4))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  mem_addr_exc_sequencer #(.WIDTH(32), .NUM_EXC(3), .VEC_BASE(253), .MEM_LAT(3), .EPC_OFFSET(4))
    dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  // Stimulus values shared by both instances
  logic [1:0]  b_sel;
  logic [31:0] b_pc, b_alu;
  logic [2:0]  b_req;
  logic [7:0]  b_rd;

  int total = 0;
  int bad   = 0;

  // Model: pos 0 = idle, 1 = vector cycle, 2..1+lat = wait, 2+lat = capture
  int          pos    [2];
  logic [1:0]  m_cause[2];
  logic [31:0] m_epc  [2];
  logic [31:0] m_hpc  [2];
  logic        m_hv   [2];
  logic [2:0]  m_pend [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic drive(input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [2:0] req, input logic [7:0] rd);
    b_sel = sel; b_pc = pc; b_alu = alu; b_req = req; b_rd = rd;
    if1.src_sel = sel; if1.in_pc = pc; if1.in_alu_out = alu; if1.exc_req = req; if1.mem_rdata = rd;
    if3.src_sel = sel; if3.in_pc = pc; if3.in_alu_out = alu; if3.exc_req = req; if3.mem_rdata = rd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset_all();
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0; m_cause[i] = '0; m_epc[i] = '0; m_hpc[i] = '0; m_hv[i] = 1'b0; m_pend[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    logic [2:0] req;
    int idx;
    m_hv[i] = 1'b0;
    if (reset) begin
      pos[i] = 0; m_cause[i] = '0; m_epc[i] = '0; m_hpc[i] = '0; m_pend[i] = '0;
    end else if (pos[i] == 0) begin
      req = b_req;
      if (PEND_EN) req = req | m_pend[i];
      if (req != 3'b000) begin
        idx = 0;
        while (!req[idx]) idx++;
        m_cause[i] = 2'(idx);
        m_epc[i]   = b_pc - 32'd4;
        m_pend[i][idx] = 1'b0;
        pos[i] = 1;
      end
    end else begin
      if (PEND_EN) m_pend[i] = m_pend[i] | b_req;
      if (pos[i] == 2 + lat_of(i)) begin
        m_hpc[i] = {24'd0, b_rd};
        m_hv[i]  = 1'b1;
        pos[i]   = 0;
      end else begin
        pos[i] = pos[i] + 1;
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] ma, input logic bsy, input logic [31:0] epc,
                          input logic [1:0] cause, input logic [31:0] hpc, input logic hv);
    string p;
    logic [31:0] exp_ma;
    p = (i == 0) ? "lat1" : "lat3";
    if (pos[i] == 0) begin
      exp_ma = (b_sel == 2'd0) ? b_pc : (b_sel == 2'd1) ? b_alu : 32'd0;
      chk({p, " mem_addr idle"}, ma, exp_ma);
    end else if (pos[i] <= 1 + lat_of(i)) begin
      chk({p, " mem_addr vec"}, ma, 32'd253 + {30'd0, m_cause[i]});
    end
    chk({p, " busy"}, {31'd0, bsy}, {31'd0, (pos[i] != 0)});
    chk({p, " epc"}, epc, m_epc[i]);
    chk({p, " exc_cause"}, {30'd0, cause}, {30'd0, m_cause[i]});
    chk({p, " handler_pc"}, hpc, m_hpc[i]);
    chk({p, " handler_valid"}, {31'd0, hv}, {31'd0, m_hv[i]});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    cmp_inst(0, if1.mem_addr, if1.busy, if1.epc, if1.exc_cause, if1.handler_pc, if1.handler_valid);
    cmp_inst(1, if3.mem_addr, if3.busy, if3.epc, if3.exc_cause, if3.handler_pc, if3.handler_valid);
  endtask

  initial begin
    int c1, c3, n1, n3;
    logic [31:0] h1, h3;
    logic saw255;

    model_reset_all();
    drive(2'd0, 32'd0, 32'd0, 3'b000, 8'd0);
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    chk("reset busy", {31'd0, if1.busy}, 32'd0);
    chk("reset epc", if1.epc, 32'd0);
    chk("reset cause", {30'd0, if1.exc_cause}, 32'd0);
    chk("reset handler_pc", if3.handler_pc, 32'd0);
    chk("reset handler_valid", {31'd0, if3.handler_valid}, 32'd0);

    // Combinational source mux in IDLE
    drive(2'd0, 32'h40, 32'h1234, 3'b000, 8'd0);
    #1 chk("mux pc", if1.mem_addr, 32'h40);
    drive(2'd1, 32'h40, 32'h1234, 3'b000, 8'd0);
    #1 chk("mux alu", if1.mem_addr, 32'h1234);
    drive(2'd2, 32'h40, 32'h1234, 3'b000, 8'd0);
    #1 chk("mux reserved", if3.mem_addr, 32'h0);
    cyc();

    // Overflow exception, handler byte 0x7C
    drive(2'd0, 32'h104, 32'h0, 3'b010, 8'h7C);
    cyc();
    drive(2'd0, 32'h104, 32'h0, 3'b000, 8'h7C);
    chk("ovf mem_addr", if1.mem_addr, 32'd254);
    chk("ovf busy", {31'd0, if1.busy}, 32'd1);
    chk("ovf epc", if1.epc, 32'h100);
    chk("ovf cause", {30'd0, if1.exc_cause}, 32'd1);
    c1 = 0; c3 = 0; n1 = 0; n3 = 0; h1 = '0; h3 = '0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (if1.handler_valid) begin n1++; c1 = c; h1 = if1.handler_pc; end
      if (if3.handler_valid) begin n3++; c3 = c; h3 = if3.handler_pc; end
    end
    chk("lat1 valid edge", c1, 32'd3);
    chk("lat3 valid edge", c3, 32'd5);
    chk("lat1 valid pulses", n1, 32'd1);
    chk("lat3 valid pulses", n3, 32'd1);
    chk("lat1 handler", h1, 32'h7C);
    chk("lat3 handler", h3, 32'h7C);

    // Priority and vector selection
    drive(2'd0, 32'h200, 32'h0, 3'b110, 8'h11);
    cyc();
    drive(2'd0, 32'h200, 32'h0, 3'b000, 8'h11);
    chk("prio cause", {30'd0, if1.exc_cause}, 32'd1);
    chk("prio mem_addr", if1.mem_addr, 32'd254);
    repeat (8) cyc();
    drive(2'd0, 32'h300, 32'h0, 3'b100, 8'h22);
    cyc();
    drive(2'd0, 32'h300, 32'h0, 3'b000, 8'h22);
    chk("div0 mem_addr", if3.mem_addr, 32'd255);
    repeat (8) cyc();

    // Reset while in WAIT
    drive(2'd0, 32'h400, 32'h0, 3'b001, 8'h33);
    cyc();
    drive(2'd0, 32'h400, 32'h0, 3'b000, 8'h33);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst wait busy", {31'd0, if1.busy}, 32'd0);
    chk("rst wait epc", if1.epc, 32'd0);
    chk("rst wait handler_pc", if1.handler_pc, 32'd0);
    chk("rst wait handler_valid", {31'd0, if1.handler_valid}, 32'd0);
    chk("rst wait lat3 busy", {31'd0, if3.busy}, 32'd0);
    cyc();

    // Request raised while busy
    drive(2'd0, 32'h500, 32'h0, 3'b010, 8'h44);
    cyc();
    drive(2'd0, 32'h500, 32'h0, 3'b000, 8'h44);
    cyc();
    drive(2'd0, 32'h500, 32'h0, 3'b100, 8'h44);
    cyc();
    drive(2'd0, 32'h500, 32'h0, 3'b000, 8'h44);
    saw255 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (if1.busy && if1.mem_addr == 32'd255) saw255 = 1'b1;
    end
    chk("busy request serviced", {31'd0, saw255}, {31'd0, PEND_EN});

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(2'($urandom_range(0, 3)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
            8'($urandom));
      cyc();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_addr_exc_sequencer.md
Name: mem_addr_exc_sequencer

Overview:
Parametrised successor to the memory-address source mux of the multicycle MIPS datapath. In normal operation it selects the memory address combinationally from PC or ALUOut. On an exception request it runs its own sequence: save EPC, drive the exception vector address, wait out the memory read latency, then capture the handler byte as the new PC. Sits between the control unit, PC/ALUOut registers and the memory address port. The control unit stalls while busy is high.

Parameters:
WIDTH, 32, datapath/address width
NUM_EXC, 3, number of exception causes (idx0 NoOp, idx1 Overflow, idx2 Div0)
VEC_BASE, 253, vector address of cause 0; cause k uses VEC_BASE+k
MEM_LAT, 1, cycles from address presented to mem_rdata valid (>=1)
EPC_OFFSET, 4, subtracted from in_pc when saving EPC

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
src_sel  in  2  normal source: 0 in_pc, 1 in_alu_out, 2/3 reserved
in_pc  in  WIDTH  current PC (already incremented)
in_alu_out  in  WIDTH  ALUOut register
exc_req  in  NUM_EXC  one bit per cause, level, sampled in IDLE only
mem_rdata  in  8  low byte of memory read data
mem_addr  out  WIDTH  memory address
busy  out  1  high in any non-IDLE state
epc  out  WIDTH  saved exception PC
exc_cause  out  CAUSE_W  index of the serviced cause; CAUSE_W = max(1, clog2(NUM_EXC))
handler_pc  out  WIDTH  zero-extended handler byte
handler_valid  out  1  one-cycle pulse when handler_pc is updated

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset; asynchronous reset is forbidden.
- Reset values: state IDLE, busy 0, epc 0, exc_cause 0, handler_pc 0, handler_valid 0, wait counter 0.
- mem_addr is combinational:
  - IDLE: src_sel 0 gives in_pc; 1 gives in_alu_out; 2/3 give 0.
  - VEC and WAIT: VEC_BASE + exc_cause, truncated to WIDTH.
- FSM states: IDLE, VEC, WAIT, CAPTURE.
- IDLE with exc_req != 0:
  - Select the lowest set index (priority idx0 > idx1 > ...).
  - Register exc_cause <= idx and epc <= in_pc - EPC_OFFSET (mod 2^WIDTH).
  - Load counter <= MEM_LAT - 1 and move to VEC.
- VEC: present the vector address for one cycle, then move to WAIT.
- WAIT: decrement the counter and hold while it is nonzero. When the counter is 0, move to CAPTURE.
  - With MEM_LAT=1, WAIT lasts one cycle.
- CAPTURE: register handler_pc <= {zeros, mem_rdata}, pulse handler_valid=1 for exactly this cycle's registered output, then go to IDLE.
- Latency: exc_req sampled at edge N gives handler_valid high in the cycle after edge N+2+MEM_LAT.
- busy is high from VEC through CAPTURE inclusive.
- exc_req bits asserted while busy are ignored (dropped) unless the optional feature is enabled.
- epc, exc_cause and handler_pc hold their values until the next exception.
- Reset mid-sequence: return to IDLE on the next edge, clear all registers, no handler_valid pulse.
- exc_req == 0 in IDLE: no state change.

Optional Feature:
Macro MEM_ADDR_EXC_PENDING_EN.
- Defined:
  - A NUM_EXC-bit pending register ORs in exc_req bits seen while busy.
  - In IDLE, the effective request is exc_req | pending.
  - The serviced bit is cleared from pending on entry to VEC.
  - Reset clears pending.
- Undefined: no pending register; requests during busy are dropped.

Decomposition:
- Shared package:
  - state enum (IDLE, VEC, WAIT, CAPTURE);
  - cause index constants (EXC_NOOP=0, EXC_OVF=1, EXC_DIV0=2);
  - src_sel encodings (SRC_PC=0, SRC_ALU=1).
- One sub-module, exc_priority_enc: combinational NUM_EXC-input lowest-index priority encoder producing index and valid.

Test Plan:
- IDLE, src_sel=0, in_pc=0x40, then src_sel=1, in_alu_out=0x1234 -> mem_addr 0x40 then 0x1234 in the same cycles; src_sel=2 -> 0; busy 0.
- MEM_LAT=1, in_pc=0x104, exc_req=3'b010, mem_rdata=0x7C during WAIT:
  - mem_addr=254 during VEC/WAIT;
  - epc=0x100, exc_cause=1;
  - handler_pc=0x7C with a single-cycle handler_valid 4 cycles after the request edge.
- exc_req=3'b110 -> exc_cause=1 and mem_addr=254; exc_req=3'b100 -> mem_addr=255.
- MEM_LAT=3 -> WAIT lasts 3 cycles; handler_valid arrives 6 cycles after the request; busy high throughout.
- reset asserted during WAIT -> next cycle IDLE, busy 0, epc/handler_pc 0, no handler_valid.
- Request during busy:
  - exc_req=3'b100 pulsed during WAIT of a cause-1 sequence;
  - without macro -> no second sequence;
  - with MEM_ADDR_EXC_PENDING_EN -> second sequence starts right after return to IDLE with mem_addr=255.
